// File: rtl/usb_tx_pkg.sv
// Shared encodings and CRC16 helper for the USB transmit/receive packet path.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPid,
        StData,
        StCrcLo,
        StCrcHi
    } state_e;

    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;

    localparam logic [15:0] CRC16_POLY      = 16'h8005;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

    localparam int unsigned MAX_PAYLOAD_DEFAULT = 1024;

    // Reflected CRC16: data bits enter LSB first.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC16_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_tx_packet_builder_if.sv
// Command, FIFO read-side and UTMI transmit signals of the packet builder.
// Stats ports exist only when USB_TX_PKT_STATS_EN is defined.
interface usb_tx_packet_builder_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned CSIZE = 11
);
    logic             start;
    logic [3:0]       pid;
    logic [CSIZE-1:0] byte_count;
    logic [DSIZE-1:0] fifo_read_data;
    logic             fifo_empty;
    logic             fifo_read_enable;
    logic             fifo_clear;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;
    logic             underrun;
    logic             len_error;
`ifdef USB_TX_PKT_STATS_EN
    logic [15:0]      pkt_count;
    logic [7:0]       underrun_count;
`endif

    modport master (
        input  start, pid, byte_count, fifo_read_data, fifo_empty, tx_ready,
        output fifo_read_enable, fifo_clear, tx_data, tx_valid, busy, done, underrun, len_error
`ifdef USB_TX_PKT_STATS_EN
        , output pkt_count, underrun_count
`endif
    );

    modport slave (
        output start, pid, byte_count, fifo_read_data, fifo_empty, tx_ready,
        input  fifo_read_enable, fifo_clear, tx_data, tx_valid, busy, done, underrun, len_error
`ifdef USB_TX_PKT_STATS_EN
        , input pkt_count, underrun_count
`endif
    );

endinterface

// File: rtl/usb_crc16.sv
// Combinational one-byte step of the USB CRC16; shared with the receive checker.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    assign crc_out = crc16_next(crc_in, data);

endmodule

// File: rtl/usb_tx_packet_builder.sv
// Drains a payload from the FIFO and frames it as PID + payload + CRC16 onto UTMI.
// Optional USB_TX_PKT_STATS_EN adds packet and underrun counters.
module usb_tx_packet_builder
    import usb_tx_pkg::*;
#(
    parameter int unsigned DSIZE       = 8,
    parameter int unsigned CSIZE       = 11,
    parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_DEFAULT
) (
    input logic                     clk,
    input logic                     rst,
    usb_tx_packet_builder_if.master bus
);

    state_e           state_q, state_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;
    logic             len_error_q, len_error_d;
    logic             fifo_clear_q, fifo_clear_d;
    logic [15:0]      crc_q, crc_d, crc_next;
    logic [CSIZE-1:0] remaining_q, remaining_d;
    logic [DSIZE-1:0] fifo_byte;
    logic             fifo_read_enable;
    logic             xfer;
    logic             len_ok;

    assign fifo_byte = bus.fifo_read_data;
    assign xfer      = tx_valid_q & bus.tx_ready;
    assign len_ok    = 32'(bus.byte_count) <= MAX_PAYLOAD;

    usb_crc16 u_crc16 (
        .crc_in  (crc_q),
        .data    (fifo_byte),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            len_error_q  <= 1'b0;
            fifo_clear_q <= 1'b0;
            crc_q        <= CRC16_INIT;
            remaining_q  <= '0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
            len_error_q  <= len_error_d;
            fifo_clear_q <= fifo_clear_d;
            crc_q        <= crc_d;
            remaining_q  <= remaining_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        tx_data_d        = tx_data_q;
        tx_valid_d       = tx_valid_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        underrun_d       = 1'b0;
        len_error_d      = 1'b0;
        fifo_clear_d     = 1'b0;
        crc_d            = crc_q;
        remaining_d      = remaining_q;
        fifo_read_enable = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (len_ok) begin
                        remaining_d = bus.byte_count;
                        crc_d       = CRC16_INIT;
                        tx_data_d   = {~bus.pid, bus.pid};
                        tx_valid_d  = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = StPid;
                    end else begin
                        len_error_d = 1'b1;
                    end
                end
            end
            StPid, StData: begin
                // Next byte is chosen on the transfer edge so the stream has no bubbles.
                if (xfer) begin
                    if (remaining_q == '0) begin
                        tx_data_d = ~crc_q[7:0];
                        state_d   = StCrcLo;
                    end else if (!bus.fifo_empty) begin
                        fifo_read_enable = 1'b1;
                        tx_data_d        = fifo_byte;
                        crc_d            = crc_next;
                        remaining_d      = remaining_q - CSIZE'(1);
                        state_d          = StData;
                    end else begin
                        tx_valid_d   = 1'b0;
                        underrun_d   = 1'b1;
                        fifo_clear_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = StIdle;
                    end
                end
            end
            StCrcLo: begin
                if (xfer) begin
                    tx_data_d = ~crc_q[15:8];
                    state_d   = StCrcHi;
                end
            end
            StCrcHi: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.tx_data          = tx_data_q;
    assign bus.tx_valid         = tx_valid_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.underrun         = underrun_q;
    assign bus.len_error        = len_error_q;
    assign bus.fifo_clear       = fifo_clear_q;
    assign bus.fifo_read_enable = fifo_read_enable;

`ifdef USB_TX_PKT_STATS_EN
    logic [15:0] pkt_count_q;
    logic [7:0]  underrun_count_q;

    // Counters advance on the same edge that raises the done/underrun pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count_q      <= 16'h0000;
            underrun_count_q <= 8'h00;
        end else begin
            if (done_d) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            if (underrun_d && (underrun_count_q != 8'hFF)) begin
                underrun_count_q <= underrun_count_q + 8'd1;
            end
        end
    end

    assign bus.pkt_count      = pkt_count_q;
    assign bus.underrun_count = underrun_count_q;
`endif

endmodule

// File: tb/tb_usb_tx_packet_builder.sv
// Directed bench: FIFO model, UTMI sink with optional backpressure, stream capture.
module tb_usb_tx_packet_builder;
    import usb_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    usb_tx_packet_builder_if #(.DSIZE(8), .CSIZE(11)) bus ();

    usb_tx_packet_builder #(.DSIZE(8), .CSIZE(11), .MAX_PAYLOAD(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // FIFO model: write side from tasks, read side from the monitor process.
    logic [7:0] fifo_mem [64];
    logic [5:0] wr_ptr = '0;
    logic [5:0] rd_ptr = '0;
    assign bus.fifo_empty     = (rd_ptr == wr_ptr);
    assign bus.fifo_read_data = fifo_mem[rd_ptr];

    int           pop_cnt  = 0;
    int           done_cnt = 0;
    int           clr_cnt  = 0;
    int           bad_pop  = 0;
    int           stab_err = 0;
    int           rx_len   = 0;
    logic [127:0] rx_sig   = '0;
    logic         hold_pend = 1'b0;
    logic [7:0]   hold_data = 8'h00;
    bit           toggle = 1'b0;

    always @(posedge clk) begin
        if (bus.fifo_read_enable) begin
            if (bus.fifo_empty) bad_pop <= bad_pop + 1;
            rd_ptr  <= rd_ptr + 6'd1;
            pop_cnt <= pop_cnt + 1;
        end else if (bus.fifo_clear) begin
            rd_ptr  <= wr_ptr;
        end
        if (rst) begin
            if (bus.tx_valid && bus.tx_ready) begin
                rx_sig <= {rx_sig[119:0], bus.tx_data};
                rx_len <= rx_len + 1;
            end
            if (bus.done) done_cnt <= done_cnt + 1;
            if (bus.fifo_clear) clr_cnt <= clr_cnt + 1;
            if (hold_pend && !(bus.tx_valid && bus.tx_data == hold_data)) stab_err <= stab_err + 1;
        end
        hold_pend <= rst && bus.tx_valid && !bus.tx_ready;
        hold_data <= bus.tx_data;
    end

    task automatic fifo_push(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic load_digits();
        for (int i = 0; i < 9; i++) fifo_push(8'(8'h31 + i));
    endtask

    task automatic issue_start(input logic [3:0] p, input logic [10:0] n);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.pid = p;
        bus.byte_count = n;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_end(input int max, output int cyc, output bit hit);
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < max) begin
            @(posedge clk); #1;
            cyc++;
            if (toggle) bus.tx_ready = ~bus.tx_ready;
            if (bus.done || bus.underrun) hit = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #3;
        n_vec++;
        if (bus.tx_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data);
        end
        n_vec++;
        if ({bus.tx_valid, bus.busy, bus.done, bus.underrun, bus.len_error, bus.fifo_clear,
             bus.fifo_read_enable} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000000",
                {bus.tx_valid, bus.busy, bus.done, bus.underrun, bus.len_error, bus.fifo_clear,
                 bus.fifo_read_enable});
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_zlp();
        int cyc; bit hit; int l0, p0, d0;
        l0 = rx_len; p0 = pop_cnt; d0 = done_cnt;
        issue_start(PID_DATA0, 11'd0);
        n_vec++;
        if ({bus.tx_valid, bus.busy, bus.tx_data} !== {2'b11, 8'hC3}) begin
            n_fail++; $display("FAIL zlp_first: got %b/%b/%h want 1/1/c3",
                bus.tx_valid, bus.busy, bus.tx_data);
        end
        wait_end(20, cyc, hit);
        n_vec++;
        if (!hit || cyc != 3 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL zlp_done: got hit=%0d cyc=%0d done=%b busy=%b want 1 3 1 0",
                hit, cyc, bus.done, bus.busy);
        end
        @(posedge clk); #1;
        n_vec++;
        if (rx_len - l0 != 3 || rx_sig[23:0] !== 24'hC30000) begin
            n_fail++; $display("FAIL zlp_stream: got %0d bytes %h want 3 bytes c30000",
                rx_len - l0, rx_sig[23:0]);
        end
        n_vec++;
        if (pop_cnt != p0 || done_cnt - d0 != 1 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL zlp_pops_done: got pops=%0d dones=%0d done=%b want 0 1 0",
                pop_cnt - p0, done_cnt - d0, bus.done);
        end
    endtask

    task automatic test_crc();
        int cyc; bit hit; int l0, p0, d0;
        l0 = rx_len; p0 = pop_cnt; d0 = done_cnt;
        load_digits();
        issue_start(PID_DATA1, 11'd9);
        n_vec++;
        if (bus.tx_data !== 8'h4B) begin
            n_fail++; $display("FAIL crc_pid: got %h want 4b", bus.tx_data);
        end
        wait_end(40, cyc, hit);
        n_vec++;
        if (!hit || cyc != 12) begin
            n_fail++; $display("FAIL crc_latency: got hit=%0d cyc=%0d want 1 12", hit, cyc);
        end
        @(posedge clk); #1;
        n_vec++;
        if (rx_len - l0 != 12 || rx_sig[95:0] !== 96'h4B313233343536373839C8B4) begin
            n_fail++; $display("FAIL crc_stream: got %0d bytes %h want 12 bytes %h",
                rx_len - l0, rx_sig[95:0], 96'h4B313233343536373839C8B4);
        end
        n_vec++;
        if (pop_cnt - p0 != 9 || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL crc_counts: got pops=%0d dones=%0d want 9 1",
                pop_cnt - p0, done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int cyc; bit hit; int l0, s0, d0;
        l0 = rx_len; s0 = stab_err; d0 = done_cnt;
        load_digits();
        issue_start(PID_DATA1, 11'd9);
        toggle = 1'b1;
        wait_end(80, cyc, hit);
        toggle = 1'b0;
        bus.tx_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (!hit || cyc <= 12) begin
            n_fail++; $display("FAIL bp_done: got hit=%0d cyc=%0d want 1 >12", hit, cyc);
        end
        n_vec++;
        if (stab_err != s0) begin
            n_fail++; $display("FAIL bp_stable: got %0d unstable holds want 0", stab_err - s0);
        end
        n_vec++;
        if (rx_len - l0 != 12 || rx_sig[95:0] !== 96'h4B313233343536373839C8B4
            || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL bp_stream: got %0d bytes %h dones=%0d want 12 bytes %h 1",
                rx_len - l0, rx_sig[95:0], done_cnt - d0, 96'h4B313233343536373839C8B4);
        end
    endtask

    task automatic test_underrun();
        int cyc; bit hit; int l0, p0, d0, c0;
        l0 = rx_len; p0 = pop_cnt; d0 = done_cnt; c0 = clr_cnt;
        fifo_push(8'hAA);
        fifo_push(8'h55);
        issue_start(PID_DATA2, 11'd4);
        n_vec++;
        if (bus.tx_data !== 8'h87) begin
            n_fail++; $display("FAIL unr_pid: got %h want 87", bus.tx_data);
        end
        wait_end(20, cyc, hit);
        n_vec++;
        if (!hit || cyc != 3
            || {bus.underrun, bus.fifo_clear, bus.tx_valid, bus.busy} !== 4'b1100) begin
            n_fail++; $display("FAIL unr_abort: got hit=%0d cyc=%0d u/c/v/b=%b want 1 3 1100",
                hit, cyc, {bus.underrun, bus.fifo_clear, bus.tx_valid, bus.busy});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({bus.underrun, bus.fifo_clear, bus.tx_valid} !== 3'b000 || clr_cnt - c0 != 1) begin
            n_fail++; $display("FAIL unr_pulse: got u/c/v=%b clears=%0d want 000 1",
                {bus.underrun, bus.fifo_clear, bus.tx_valid}, clr_cnt - c0);
        end
        n_vec++;
        if (rx_len - l0 != 3 || rx_sig[23:0] !== 24'h87AA55 || pop_cnt - p0 != 2
            || done_cnt != d0) begin
            n_fail++; $display("FAIL unr_stream: got %0d bytes %h pops=%0d dones=%0d want 3 87aa55 2 0",
                rx_len - l0, rx_sig[23:0], pop_cnt - p0, done_cnt - d0);
        end
    endtask

    task automatic test_len_error();
        int cyc; bit hit; int l0;
        l0 = rx_len;
        issue_start(PID_DATA0, 11'd1025);
        n_vec++;
        if ({bus.len_error, bus.tx_valid, bus.busy} !== 3'b100) begin
            n_fail++; $display("FAIL len_reject: got e/v/b=%b want 100",
                {bus.len_error, bus.tx_valid, bus.busy});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({bus.len_error, bus.tx_valid} !== 2'b00 || rx_len != l0) begin
            n_fail++; $display("FAIL len_after: got e/v=%b bytes=%0d want 00 0",
                {bus.len_error, bus.tx_valid}, rx_len - l0);
        end
        // Largest legal length is accepted; the empty FIFO then underruns at once.
        issue_start(PID_DATA0, 11'd1024);
        n_vec++;
        if ({bus.len_error, bus.tx_valid, bus.tx_data} !== {2'b01, 8'hC3}) begin
            n_fail++; $display("FAIL len_max_accept: got e=%b v=%b d=%h want 0 1 c3",
                bus.len_error, bus.tx_valid, bus.tx_data);
        end
        wait_end(10, cyc, hit);
        n_vec++;
        if (!hit || cyc != 1 || bus.underrun !== 1'b1) begin
            n_fail++; $display("FAIL len_max_underrun: got hit=%0d cyc=%0d u=%b want 1 1 1",
                hit, cyc, bus.underrun);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        int cyc; bit hit; int l0, d0;
        l0 = rx_len; d0 = done_cnt;
        load_digits();
        issue_start(PID_DATA0, 11'd9);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.pid = PID_DATA1;
        bus.byte_count = 11'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_end(40, cyc, hit);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (!hit || bus.tx_valid !== 1'b0 || bus.len_error !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++; $display("FAIL ign_quiet: got hit=%0d v=%b e=%b dones=%0d want 1 0 0 1",
                hit, bus.tx_valid, bus.len_error, done_cnt - d0);
        end
        n_vec++;
        if (rx_len - l0 != 12 || rx_sig[95:0] !== 96'hC3313233343536373839C8B4) begin
            n_fail++; $display("FAIL ign_stream: got %0d bytes %h want 12 bytes %h",
                rx_len - l0, rx_sig[95:0], 96'hC3313233343536373839C8B4);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit hit; int l0;
        load_digits();
        issue_start(PID_DATA1, 11'd9);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({bus.tx_valid, bus.busy} !== 2'b00) begin
            n_fail++; $display("FAIL rst_async: got v/b=%b want 00", {bus.tx_valid, bus.busy});
        end
        @(posedge clk); #1 rst = 1'b1;
        l0 = rx_len;
        issue_start(PID_DATA0, 11'd0);
        wait_end(20, cyc, hit);
        @(posedge clk); #1;
        n_vec++;
        if (!hit || cyc != 3 || rx_len - l0 != 3 || rx_sig[23:0] !== 24'hC30000) begin
            n_fail++; $display("FAIL rst_zlp: got hit=%0d cyc=%0d %0d bytes %h want 1 3 3 c30000",
                hit, cyc, rx_len - l0, rx_sig[23:0]);
        end
        n_vec++;
        if (bad_pop != 0) begin
            n_fail++; $display("FAIL pop_when_empty: got %0d want 0", bad_pop);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.pid        = 4'h0;
        bus.byte_count = '0;
        bus.tx_ready   = 1'b1;
        test_reset();
        test_zlp();
        test_crc();
        test_backpressure();
        test_underrun();
        test_len_error();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
